// File: rtl/bicubic_pkg.sv
// Shared constants and arithmetic helpers for the bicubic stream core.
// Contents:
//   TAPS              - filter taps per direction (window is TAPS x TAPS)
//   ORIGIN_ROW/COL    - window position used by nearest-neighbour bypass
//   DEFAULT_FRAC_BITS - default weight fraction bits (unity = 2^FRAC_BITS)
//   acc_width()       - accumulator width for one 4-tap MAC
//   round_clip()      - round-half-up, shift down, clip to [0, 2^data_w-1]
package bicubic_pkg;

  localparam int TAPS              = 4;
  localparam int ORIGIN_ROW        = 1;
  localparam int ORIGIN_COL        = 1;
  localparam int DEFAULT_FRAC_BITS = 7;

  function automatic int acc_width(input int data_w, input int weight_w);
    return data_w + weight_w + 3;
  endfunction

  // The accumulator arrives sign-extended to 64 bits so one helper serves
  // every parameterisation; the caller truncates to its sample width.
  function automatic logic [63:0] round_clip(input logic signed [63:0] acc,
                                             input int frac_bits,
                                             input int data_w);
    logic signed [63:0] rnd;
    logic signed [63:0] max_v;
    max_v = (64'sd1 <<< data_w) - 64'sd1;
    rnd   = (acc + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits;
    if (rnd < 64'sd0) begin
      return 64'd0;
    end
    if (rnd > max_v) begin
      return max_v;
    end
    return rnd;
  endfunction

endpackage

// File: rtl/bicubic_stream_core_mac4_clip.sv
// bicubic_mac4_clip: purely combinational 4-tap multiply-accumulate with
// rounding and clipping.
// Ports:
//   samples - TAPS unsigned samples, tap k at [k*DATA_WIDTH +: DATA_WIDTH]
//   weights - TAPS signed weights, tap k at [k*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   result  - round(sum(w*s) / 2^FRAC_BITS) clipped to [0, 2^DATA_WIDTH-1]
module bicubic_mac4_clip
  import bicubic_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 9,
  parameter int FRAC_BITS    = DEFAULT_FRAC_BITS
) (
  input  logic [TAPS*DATA_WIDTH-1:0]   samples,
  input  logic [TAPS*WEIGHT_WIDTH-1:0] weights,
  output logic [DATA_WIDTH-1:0]        result
);

  localparam int ACC_W = acc_width(DATA_WIDTH, WEIGHT_WIDTH);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] s_ext;

  always_comb begin
    acc   = '0;
    w_ext = '0;
    s_ext = '0;
    for (int k = 0; k < TAPS; k++) begin
      w_ext = ACC_W'($signed(weights[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
      // Samples are unsigned: zero-extend so the top bit is never a sign.
      s_ext = ACC_W'({1'b0, samples[k*DATA_WIDTH +: DATA_WIDTH]});
      acc   = acc + w_ext * s_ext;
    end
  end

  assign result = DATA_WIDTH'(round_clip(64'(acc), FRAC_BITS, DATA_WIDTH));

endmodule

// File: rtl/bicubic_stream_core.sv
// bicubic_stream_core: multi-channel streaming bicubic interpolator.
// Each accepted beat shifts one TAPS-row column into a per-channel window
// (or replicates it on start-of-line). An emit beat launches a token through
// a 2-stage pipeline: horizontal 4-tap pass, then vertical 4-tap pass,
// each rounded and clipped. Bypass selects the origin sample instead.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid/in_ready     - input beat handshake
//   in_col                - row r, channel c at [(r*CHANNELS+c)*DATA_WIDTH +: DATA_WIDTH]
//   in_sol                - replicate in_col into all window columns
//   in_emit               - request an output from the post-shift window
//   in_bypass             - nearest (origin tap) instead of bicubic
//   h_w, v_w              - signed taps, tap k at [k*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   out_valid/out_ready   - output handshake
//   out_pixel             - channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   err_underfill         - sticky: emit requested before window was full
module bicubic_stream_core
  import bicubic_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CHANNELS     = 3,
  parameter int WEIGHT_WIDTH = 9,
  parameter int FRAC_BITS    = DEFAULT_FRAC_BITS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [TAPS*CHANNELS*DATA_WIDTH-1:0] in_col,
  input  logic                                in_sol,
  input  logic                                in_emit,
  input  logic                                in_bypass,
  input  logic [TAPS*WEIGHT_WIDTH-1:0]        h_w,
  input  logic [TAPS*WEIGHT_WIDTH-1:0]        v_w,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0]      out_pixel,
  output logic                                err_underfill
);

  localparam int WV_W = TAPS * WEIGHT_WIDTH;

  typedef logic [DATA_WIDTH-1:0] sample_t;

  // Window indexed [column][row][channel]; column 0 is the oldest.
  sample_t    win_q [TAPS][TAPS][CHANNELS];
  sample_t    win_d [TAPS][TAPS][CHANNELS];
  logic [2:0] fill_q, fill_d;
  logic       err_q, err_d;

  logic            vld_p0_q, vld_p0_d;
  logic [WV_W-1:0] hw_p0_q, hw_p0_d;
  logic [WV_W-1:0] vw_p0_q, vw_p0_d;
  logic            byp_p0_q, byp_p0_d;

  logic            vld_p1_q, vld_p1_d;
  sample_t         hres_p1_q [TAPS][CHANNELS];
  sample_t         hres_p1_d [TAPS][CHANNELS];
  sample_t         orig_p1_q [CHANNELS];
  sample_t         orig_p1_d [CHANNELS];
  logic [WV_W-1:0] vw_p1_q, vw_p1_d;
  logic            byp_p1_q, byp_p1_d;

  logic                           vld_p2_q, vld_p2_d;
  logic [CHANNELS*DATA_WIDTH-1:0] pix_p2_q, pix_p2_d;

  logic [TAPS*DATA_WIDTH-1:0] hsamp [TAPS][CHANNELS];
  logic [TAPS*DATA_WIDTH-1:0] vsamp [CHANNELS];
  sample_t                    hres [TAPS][CHANNELS];
  sample_t                    vres [CHANNELS];

  logic       out_adv, s1_adv, s0_adv, accept;
  logic [2:0] fill_post;
  logic       emit_ok;

  // A stage may load when it is empty or its contents move on this edge.
  // Holding in_ready low while an s0 token waits keeps the window frozen
  // under the horizontal MACs that read it.
  assign out_adv   = !vld_p2_q || out_ready;
  assign s1_adv    = !vld_p1_q || out_adv;
  assign s0_adv    = !vld_p0_q || s1_adv;
  assign in_ready  = s0_adv;
  assign accept    = in_valid && s0_adv;

  assign fill_post = in_sol ? 3'(TAPS)
                   : ((fill_q == 3'(TAPS)) ? fill_q : fill_q + 3'd1);
  assign emit_ok   = (fill_post == 3'(TAPS));

  // ---- E0: window update and s0 token ----
  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    err_d  = err_q;
    if (accept) begin
      fill_d = fill_post;
      for (int c = 0; c < CHANNELS; c++) begin
        for (int r = 0; r < TAPS; r++) begin
          if (in_sol) begin
            for (int k = 0; k < TAPS; k++) begin
              win_d[k][r][c] = in_col[(r*CHANNELS+c)*DATA_WIDTH +: DATA_WIDTH];
            end
          end else begin
            for (int k = 0; k < TAPS-1; k++) begin
              win_d[k][r][c] = win_q[k+1][r][c];
            end
            win_d[TAPS-1][r][c] = in_col[(r*CHANNELS+c)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      if (in_emit && !emit_ok) begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    vld_p0_d = vld_p0_q;
    hw_p0_d  = hw_p0_q;
    vw_p0_d  = vw_p0_q;
    byp_p0_d = byp_p0_q;
    if (s0_adv) begin
      vld_p0_d = accept && in_emit && emit_ok;
      if (accept) begin
        hw_p0_d  = h_w;
        vw_p0_d  = v_w;
        byp_p0_d = in_bypass;
      end
    end
  end

  // ---- E1: horizontal pass registered per row and channel ----
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      for (int r = 0; r < TAPS; r++) begin
        hsamp[r][c] = '0;
        for (int k = 0; k < TAPS; k++) begin
          hsamp[r][c][k*DATA_WIDTH +: DATA_WIDTH] = win_q[k][r][c];
        end
      end
    end
  end

  for (genvar gc = 0; gc < CHANNELS; gc++) begin : g_hch
    for (genvar gr = 0; gr < TAPS; gr++) begin : g_hrow
      bicubic_mac4_clip #(
        .DATA_WIDTH  (DATA_WIDTH),
        .WEIGHT_WIDTH(WEIGHT_WIDTH),
        .FRAC_BITS   (FRAC_BITS)
      ) u_hmac (
        .samples(hsamp[gr][gc]),
        .weights(hw_p0_q),
        .result (hres[gr][gc])
      );
    end
  end

  always_comb begin
    vld_p1_d  = vld_p1_q;
    hres_p1_d = hres_p1_q;
    orig_p1_d = orig_p1_q;
    vw_p1_d   = vw_p1_q;
    byp_p1_d  = byp_p1_q;
    if (s1_adv) begin
      vld_p1_d = vld_p0_q;
      if (vld_p0_q) begin
        hres_p1_d = hres;
        vw_p1_d   = vw_p0_q;
        byp_p1_d  = byp_p0_q;
        for (int c = 0; c < CHANNELS; c++) begin
          orig_p1_d[c] = win_q[ORIGIN_COL][ORIGIN_ROW][c];
        end
      end
    end
  end

  // ---- E2: vertical pass into the output register ----
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      vsamp[c] = '0;
      for (int r = 0; r < TAPS; r++) begin
        vsamp[c][r*DATA_WIDTH +: DATA_WIDTH] = hres_p1_q[r][c];
      end
    end
  end

  for (genvar gc = 0; gc < CHANNELS; gc++) begin : g_vch
    bicubic_mac4_clip #(
      .DATA_WIDTH  (DATA_WIDTH),
      .WEIGHT_WIDTH(WEIGHT_WIDTH),
      .FRAC_BITS   (FRAC_BITS)
    ) u_vmac (
      .samples(vsamp[gc]),
      .weights(vw_p1_q),
      .result (vres[gc])
    );
  end

  always_comb begin
    vld_p2_d = vld_p2_q;
    pix_p2_d = pix_p2_q;
    if (out_adv) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        for (int c = 0; c < CHANNELS; c++) begin
          pix_p2_d[c*DATA_WIDTH +: DATA_WIDTH] = byp_p1_q ? orig_p1_q[c] : vres[c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q    <= '{default: '0};
      fill_q   <= '0;
      err_q    <= 1'b0;
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      pix_p2_q <= '0;
    end else begin
      win_q    <= win_d;
      fill_q   <= fill_d;
      err_q    <= err_d;
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      pix_p2_q <= pix_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    hw_p0_q   <= hw_p0_d;
    vw_p0_q   <= vw_p0_d;
    byp_p0_q  <= byp_p0_d;
    hres_p1_q <= hres_p1_d;
    orig_p1_q <= orig_p1_d;
    vw_p1_q   <= vw_p1_d;
    byp_p1_q  <= byp_p1_d;
  end

  assign out_valid     = vld_p2_q;
  assign out_pixel     = pix_p2_q;
  assign err_underfill = err_q;

endmodule

// File: tb/tb_bicubic_stream_core.sv
// Self-checking bench for bicubic_stream_core: table-driven arithmetic
// vectors, hand-written underfill/backpressure/reset sequences, and a
// randomized run scored against an array/queue reference model.
module tb_bicubic_stream_core;

  localparam int DW = 8;
  localparam int CH = 3;
  localparam int WW = 9;
  localparam int FB = 7;
  localparam int CW = 4 * CH * DW;
  localparam int WV = 4 * WW;
  localparam int PW = CH * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_sol, in_emit, in_bypass;
  logic [CW-1:0] in_col;
  logic [WV-1:0] h_w, v_w;
  logic          out_valid, out_ready, err_underfill;
  logic [PW-1:0] out_pixel;

  bicubic_stream_core #(
    .DATA_WIDTH(DW), .CHANNELS(CH), .WEIGHT_WIDTH(WW), .FRAC_BITS(FB)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_col(in_col), .in_sol(in_sol), .in_emit(in_emit), .in_bypass(in_bypass),
    .h_w(h_w), .v_w(v_w), .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .err_underfill(err_underfill)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: window as plain integers [channel][row][column].
  int            mw [CH][4][4];
  int            mfill;
  bit            merr;
  logic [PW-1:0] expq [$];
  bit            prev_stall;
  logic [PW-1:0] prev_pix;

  typedef struct {
    logic [31:0]   p;    // column values p0..p3, p0 in bits [7:0]
    logic [WV-1:0] hw;
    logic [WV-1:0] vw;
    bit            byp;
    logic [7:0]    exp;
  } vec_t;

  vec_t vt [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WV-1:0] pw(input int a, input int b, input int c, input int d);
    logic [WW-1:0] ta, tb, tc, td;
    ta = WW'(a); tb = WW'(b); tc = WW'(c); td = WW'(d);
    return {td, tc, tb, ta};
  endfunction

  function automatic int wsel(input logic [WV-1:0] w, input int k);
    logic signed [WW-1:0] t;
    t = w[k*WW +: WW];
    return int'(t);
  endfunction

  // Weighted sum divided by 2^FB, rounded half up, clipped to the sample range.
  function automatic int filt(input int s0, input int s1, input int s2, input int s3,
                              input logic [WV-1:0] w);
    int acc, r;
    acc = s0 * wsel(w, 0) + s1 * wsel(w, 1) + s2 * wsel(w, 2) + s3 * wsel(w, 3);
    r = (acc + (1 << (FB - 1))) >>> FB;
    if (r < 0) r = 0;
    if (r > (1 << DW) - 1) r = (1 << DW) - 1;
    return r;
  endfunction

  function automatic logic [PW-1:0] model_out(input bit byp, input logic [WV-1:0] hw,
                                               input logic [WV-1:0] vw);
    logic [PW-1:0] pix;
    int h [4];
    int v;
    pix = '0;
    for (int c = 0; c < CH; c++) begin
      if (byp) begin
        v = mw[c][1][1];
      end else begin
        for (int r = 0; r < 4; r++) h[r] = filt(mw[c][r][0], mw[c][r][1], mw[c][r][2], mw[c][r][3], hw);
        v = filt(h[0], h[1], h[2], h[3], vw);
      end
      pix[c*DW +: DW] = DW'(v);
    end
    return pix;
  endfunction

  task automatic model_accept(input logic [CW-1:0] col, input bit sol, input bit emit,
                              input bit byp, input logic [WV-1:0] hw, input logic [WV-1:0] vw);
    int s;
    for (int c = 0; c < CH; c++) begin
      for (int r = 0; r < 4; r++) begin
        s = int'(col[(r*CH+c)*DW +: DW]);
        if (sol) begin
          for (int k = 0; k < 4; k++) mw[c][r][k] = s;
        end else begin
          for (int k = 0; k < 3; k++) mw[c][r][k] = mw[c][r][k+1];
          mw[c][r][3] = s;
        end
      end
    end
    mfill = sol ? 4 : ((mfill < 4) ? mfill + 1 : 4);
    if (emit) begin
      if (mfill == 4) expq.push_back(model_out(byp, hw, vw));
      else merr = 1'b1;
    end
  endtask

  // One clock cycle: check held output and sticky error, drive inputs,
  // score any output transfer, update the model on accept. Returns at posedge.
  task automatic cycle(input bit v, input logic [CW-1:0] col, input bit sol, input bit emit,
                       input bit byp, input logic [WV-1:0] hw, input logic [WV-1:0] vw,
                       input bit ordy, output bit accepted);
    logic [PW-1:0] e;
    @(negedge clk);
    if (prev_stall) begin
      check("hold_valid", out_valid, 1);
      check("hold_pixel", out_pixel, prev_pix);
    end
    check("err_underfill", err_underfill, merr);
    in_valid = v; in_col = col; in_sol = sol; in_emit = emit; in_bypass = byp;
    h_w = hw; v_w = vw; out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got pixel %0h with no output expected", out_pixel);
      end else begin
        e = expq.pop_front();
        if (out_pixel !== e) begin
          errors++;
          $display("FAIL out_pixel: got %0h expected %0h", out_pixel, e);
        end
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_pix   = out_pixel;
    accepted   = v && in_ready;
    if (accepted) model_accept(col, sol, emit, byp, hw, vw);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_sol = 1'b0; in_emit = 1'b0; in_bypass = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_pixel", out_pixel, 0);
    check("rst_err", err_underfill, 0);
    rst = 1'b0;
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++) mw[c][r][k] = 0;
    mfill = 0; merr = 1'b0; prev_stall = 1'b0;
    expq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            a;
    logic [7:0]    b;
    logic [CW-1:0] rcol;
    logic [WV-1:0] rhw, rvw;
    bit            rv, rsol, remit, rbyp, pending;
    int            cyc, sent, acc_low;
    logic [CW-1:0] bcol [8];
    logic [WV-1:0] bhw  [8];

    rst = 1'b1; in_valid = 1'b0; in_col = '0; in_sol = 1'b0; in_emit = 1'b0;
    in_bypass = 1'b0; h_w = '0; v_w = '0; out_ready = 1'b1;
    prev_stall = 1'b0; prev_pix = '0;

    vt[0] = '{p: {8'd100, 8'd100, 8'd100, 8'd100}, hw: pw(-9, 73, 73, -9),
              vw: pw(-9, 73, 73, -9), byp: 1'b0, exp: 8'd100};
    vt[1] = '{p: {8'd0, 8'd0, 8'd255, 8'd0}, hw: pw(-16, 80, 80, -16),
              vw: pw(0, 128, 0, 0), byp: 1'b0, exp: 8'd159};
    vt[2] = '{p: {8'd0, 8'd0, 8'd255, 8'd0}, hw: pw(0, 144, 0, -16),
              vw: pw(0, 128, 0, 0), byp: 1'b0, exp: 8'd255};
    vt[3] = '{p: {8'd255, 8'd0, 8'd0, 8'd255}, hw: pw(-16, 80, 80, -16),
              vw: pw(0, 128, 0, 0), byp: 1'b0, exp: 8'd0};
    vt[4] = '{p: {8'h33, 8'h22, 8'h5A, 8'h11}, hw: pw(100, -200, 3, 7),
              vw: pw(-50, 17, 255, -256), byp: 1'b1, exp: 8'h5A};

    do_reset();

    // Table vectors: sol with p0, shift p1..p3, emit on p3; check latency 2.
    for (int i = 0; i < 5; i++) begin
      b = vt[i].p[7:0];   cycle(1'b1, {12{b}}, 1'b1, 1'b0, 1'b0, vt[i].hw, vt[i].vw, 1'b1, a);
      b = vt[i].p[15:8];  cycle(1'b1, {12{b}}, 1'b0, 1'b0, 1'b0, vt[i].hw, vt[i].vw, 1'b1, a);
      b = vt[i].p[23:16]; cycle(1'b1, {12{b}}, 1'b0, 1'b0, 1'b0, vt[i].hw, vt[i].vw, 1'b1, a);
      b = vt[i].p[31:24]; cycle(1'b1, {12{b}}, 1'b0, 1'b1, vt[i].byp, vt[i].hw, vt[i].vw, 1'b1, a);
      #1; check("vec_lat_e0", out_valid, 0);
      idle(1);
      #1; check("vec_lat_e1", out_valid, 0);
      idle(1);
      #1; check("vec_valid", out_valid, 1);
      b = vt[i].exp;
      check("vec_pixel", out_pixel, {3{b}});
      idle(2);
    end

    // sol and emit on the same beat emit the replicated window.
    b = 8'd77;
    cycle(1'b1, {12{b}}, 1'b1, 1'b1, 1'b0, pw(-9, 73, 73, -9), pw(0, 128, 0, 0), 1'b1, a);
    idle(2);
    #1; check("sol_emit_pixel", out_pixel, {3{b}});
    idle(2);

    // Underfill: three shifts after reset, emit on the third.
    do_reset();
    for (int i = 0; i < 3; i++)
      cycle(1'b1, {$urandom(), $urandom(), $urandom()}, 1'b0, (i == 2), 1'b0,
            pw(0, 128, 0, 0), pw(0, 128, 0, 0), 1'b1, a);
    idle(3);
    #1; check("underfill_no_valid", out_valid, 0);
    check("underfill_err", err_underfill, 1);
    cycle(1'b1, {$urandom(), $urandom(), $urandom()}, 1'b0, 1'b1, 1'b0,
          pw(-9, 73, 73, -9), pw(-9, 73, 73, -9), 1'b1, a);
    idle(2);
    #1; check("underfill_fourth_valid", out_valid, 1);
    check("underfill_err_sticky", err_underfill, 1);
    idle(2);

    // Backpressure: 8 back-to-back emits, out_ready low for the first 5 cycles.
    b = 8'd10;
    cycle(1'b1, {12{b}}, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1, a);
    for (int i = 0; i < 8; i++) begin
      bcol[i] = {$urandom(), $urandom(), $urandom()};
      bhw[i]  = pw(-9 - i, 73 + i, 73, -9);
    end
    cyc = 0; sent = 0; acc_low = 0;
    while (sent < 8 && cyc < 60) begin
      cycle(1'b1, bcol[sent], 1'b0, 1'b1, 1'b0, bhw[sent], pw(-9, 73, 73, -9), (cyc >= 5), a);
      if (a) begin
        if (cyc < 5) acc_low++;
        sent++;
      end
      if (cyc == 4) begin
        #1; check("bp_in_ready_low", in_ready, 0);
      end
      cyc++;
    end
    check("bp_sent", sent, 8);
    check("bp_accepts_while_stalled", acc_low, 3);
    idle(10);
    check("bp_drained", expq.size(), 0);

    // Reset with two tokens in flight discards them.
    b = 8'd200;
    cycle(1'b1, {12{b}}, 1'b1, 1'b1, 1'b0, pw(0, 128, 0, 0), pw(0, 128, 0, 0), 1'b1, a);
    cycle(1'b1, {12{b}}, 1'b0, 1'b1, 1'b1, pw(0, 128, 0, 0), pw(0, 128, 0, 0), 1'b1, a);
    do_reset();
    idle(6);
    #1; check("rst_flush_no_valid", out_valid, 0);

    // Randomized traffic with random backpressure against the model.
    pending = 1'b0;
    rcol = '0; rhw = '0; rvw = '0; rv = 1'b0; rsol = 1'b0; remit = 1'b0; rbyp = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if (!pending) begin
        rcol  = {$urandom(), $urandom(), $urandom()};
        rsol  = ($urandom_range(0, 7) == 0);
        remit = ($urandom_range(0, 1) == 1);
        rbyp  = ($urandom_range(0, 3) == 0);
        rhw   = pw($urandom_range(0, 511), $urandom_range(0, 511),
                   $urandom_range(0, 511), $urandom_range(0, 511));
        rvw   = pw($urandom_range(0, 511), $urandom_range(0, 511),
                   $urandom_range(0, 511), $urandom_range(0, 511));
        rv    = ($urandom_range(0, 3) != 0);
      end
      cycle(rv, rcol, rsol, remit, rbyp, rhw, rvw, ($urandom_range(0, 3) != 0), a);
      pending = rv && !a;
    end
    idle(10);
    check("rand_drained", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
